bp_coh_wormhole_concentrator: RTL and testbench
===============================================

BP_COH_WORMHOLE_CONCENTRATOR -- requirements
Module: bp_coh_wormhole_concentrator

Interface
REQ-001 SHALL have parameter flit_width_p, default 64: coherence NoC flit width in bits.
REQ-002 SHALL have parameter len_width_p, default 4: width of the wormhole length field.
REQ-003 SHALL have parameter len_lsb_p, default 0: bit position of the length field LSB in a header flit.
REQ-004 SHALL have parameter num_in_p, default 4, legal range 2..16: number of input channels.
REQ-005 SHALL have parameter fifo_els_p, default 2, minimum 2: depth of each input FIFO.
REQ-006 SHALL have parameter cnt_width_p, default 16: width of the packet counter.
REQ-007 SHALL fix the clocking as one clock with asynchronous, active-high reset.
REQ-008 SHALL provide port coh_clk_i  in  1: the single clock.
REQ-009 SHALL provide port coh_reset_i  in  1: asynchronous active-high reset.
REQ-010 SHALL provide port in_link_i  in  num_in_p x link_w: input links, link_w = flit_width_p+2 = {v, data, ready_and_rev}; only v and data are used.
REQ-011 SHALL provide port in_link_o  out  num_in_p x link_w: only ready_and_rev is driven; v and data are tied 0.
REQ-012 SHALL provide port out_link_o  out  link_w: v and data are driven; ready_and_rev is tied 0.
REQ-013 SHALL provide port out_link_i  in  link_w: only ready_and_rev is used.
REQ-014 SHALL provide port chan_en_i  in  num_in_p: per-channel arbitration enable (runtime stubbing).
REQ-015 SHALL provide port pkt_count_o  out  cnt_width_p: count of completed output packets.

Function
REQ-016 SHALL give each channel i a FIFO of fifo_els_p flits.
REQ-017 SHALL enqueue a flit on channel i when in_link_i[i].v and in_link_o[i].ready_and_rev are both 1.
REQ-018 SHALL drive in_link_o[i].ready_and_rev = FIFO i not full, registered-full based, with no combinational path from out_link_i.
REQ-019 SHALL NOT enqueue while the FIFO is full, even when a dequeue occurs in the same cycle.
REQ-020 SHALL treat a flit as a header when no packet is locked on its channel.
REQ-021 SHALL define the header length L as bits [len_lsb_p+len_width_p-1 : len_lsb_p], the number of body flits that follow; L=0 is a single-flit packet.
REQ-022 SHALL implement states IDLE and LOCKED.
REQ-023 In IDLE, SHALL grant round-robin among channels that are non-empty and have chan_en_i=1, searching from priority pointer ptr upward with wrap-around.
REQ-024 SHALL make the grant decision combinationally in IDLE, so the header may be presented on out_link_o in the same cycle.
REQ-025 SHALL, on a header transfer (out v & ready_and_rev) with L>0, move to LOCKED with owner=granted channel and remaining=L.
REQ-026 SHALL, on a header transfer with L=0, stay in IDLE and count the packet complete.
REQ-027 SHALL set ptr = (granted+1) mod num_in_p on each header transfer.
REQ-028 In LOCKED, SHALL present only the owner's FIFO head, decrement remaining on each transfer, and return to IDLE, counting the packet complete, when the transfer with remaining=1 occurs.
REQ-029 SHALL deassert out_link_o.v in LOCKED while the owner FIFO is empty (bubble); no other channel may interleave.
REQ-030 SHALL let chan_en_i deassertion affect only new IDLE grants; a locked packet SHALL complete even when its channel is disabled.
REQ-031 SHALL keep out_link_o.v and data stable until accepted, and SHALL NOT drop or duplicate any flit.
REQ-032 SHALL increment pkt_count_o by 1 per completed packet, saturating at all-ones.

Reset
REQ-033 SHALL, on coh_reset_i assertion at any time including mid-packet, asynchronously clear all FIFOs to empty, state to IDLE, ptr to 0, remaining to 0, and pkt_count_o to 0.
REQ-034 SHALL hold out_link_o.v=0 and all in_link_o ready_and_rev=0 while reset is asserted.
REQ-035 SHALL set ready_and_rev to 1 on all channels in the first cycle after reset deasserts.
REQ-036 SHALL discard any partially transferred packet on reset with no resumption.

Verification
REQ-037 Single packet: ch0 sends header L=2 plus 2 body flits, out ready=1 -> 3 flits out in order on consecutive cycles, pkt_count_o=1, state returns to IDLE.
REQ-038 Fairness: all 4 channels send back-to-back L=0 packets, chan_en_i=4'b1111 -> output order ch0,ch1,ch2,ch3,ch0... with ptr wrapping 3->0.
REQ-039 No interleave: ch1 sends L=3 with one bubble between body flits while ch2 has a ready header -> ch2's header appears only after ch1's 4th flit.
REQ-040 Backpressure: out ready_and_rev=0 for 10 cycles with fifo_els_p=2 -> each channel accepts exactly 2 flits then ready_and_rev=0; on release all flits drain intact.
REQ-041 Disable mid-packet: clear chan_en_i[0] after ch0's header L=2 -> ch0 body completes; later ch0 headers are not granted until re-enabled.
REQ-042 Reset mid-packet plus saturation: assert reset after the 2nd flit of L=5 -> out v=0 immediately, counter=0; separately preload with cnt_width_p=2 and send 5 packets -> pkt_count_o holds at 3.

Source files
------------

// File: rtl/bp_coh_wormhole_concentrator.sv
`default_nettype none
// ============================================================================
// Module  : bp_coh_wormhole_concentrator
// Brief   : N-to-1 wormhole concentrator with per-channel FIFOs and RR grant.
// Revision: 1.0 - initial release
// ============================================================================
module bp_coh_wormhole_concentrator #(
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_lsb_p    = 0,
  parameter int num_in_p     = 4,
  parameter int fifo_els_p   = 2,
  parameter int cnt_width_p  = 16
) (
  input  logic                                   coh_clk_i,
  input  logic                                   coh_reset_i,
  input  logic [num_in_p-1:0][flit_width_p+1:0]  in_link_i,
  output logic [num_in_p-1:0][flit_width_p+1:0]  in_link_o,
  output logic [flit_width_p+1:0]                out_link_o,
  input  logic [flit_width_p+1:0]                out_link_i,
  input  logic [num_in_p-1:0]                    chan_en_i,
  output logic [cnt_width_p-1:0]                 pkt_count_o
);

  localparam int c_ptr_w  = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int c_addr_w = $clog2(fifo_els_p);
  localparam int c_cnt_w  = $clog2(fifo_els_p + 1);

  localparam logic [c_ptr_w-1:0]     c_last_ch  = c_ptr_w'(num_in_p - 1);
  localparam logic [c_addr_w-1:0]    c_last_el  = c_addr_w'(fifo_els_p - 1);
  localparam logic [c_cnt_w-1:0]     c_cnt_full = c_cnt_w'(fifo_els_p);
  localparam logic [c_ptr_w:0]       c_num_in   = (c_ptr_w+1)'(num_in_p);
  localparam logic [len_width_p-1:0] c_rem_one  = len_width_p'(1);

  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_locked = 1'b1;

  logic [num_in_p-1:0]     w_full, w_empty, w_ready, w_enq, w_deq, w_req, w_in_rr;
  logic [flit_width_p-1:0] w_head [num_in_p];

  logic [0:0]             r_state, w_state_nxt;
  logic [c_ptr_w-1:0]     r_ptr, w_ptr_nxt, r_owner, w_owner_nxt;
  logic [len_width_p-1:0] r_rem, w_rem_nxt, w_len;
  logic [cnt_width_p-1:0] r_pkt_cnt;

  logic [c_ptr_w-1:0]      w_gnt_idx, w_cand, w_sel;
  logic [c_ptr_w:0]        w_sum;
  logic                    w_gnt_v, w_out_v, w_xfer, w_pkt_done;
  logic [flit_width_p-1:0] w_out_data;

  for (genvar i = 0; i < num_in_p; i++) begin : g_fifo
    logic [flit_width_p-1:0] r_mem [fifo_els_p];
    logic [c_addr_w-1:0]     r_wr, r_rd;
    logic [c_cnt_w-1:0]      r_cnt;

    assign w_full[i]  = (r_cnt == c_cnt_full);
    assign w_empty[i] = (r_cnt == '0);
    // Ready depends only on registered occupancy, never on the output side.
    assign w_ready[i] = ~w_full[i] & ~coh_reset_i;
    assign w_enq[i]   = in_link_i[i][flit_width_p+1] & w_ready[i];
    assign w_req[i]   = ~w_empty[i] & chan_en_i[i];
    assign w_head[i]  = r_mem[r_rd];
    assign w_in_rr[i] = in_link_i[i][0];
    assign in_link_o[i] = {{(flit_width_p+1){1'b0}}, w_ready[i]};

    always_ff @(posedge coh_clk_i) begin
      if (w_enq[i]) r_mem[r_wr] <= in_link_i[i][flit_width_p:1];
    end

    always_ff @(posedge coh_clk_i or posedge coh_reset_i) begin
      if (coh_reset_i) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_enq[i]) r_wr <= (r_wr == c_last_el) ? '0 : r_wr + 1'b1;
        if (w_deq[i]) r_rd <= (r_rd == c_last_el) ? '0 : r_rd + 1'b1;
        if (w_enq[i] && !w_deq[i])      r_cnt <= r_cnt + 1'b1;
        else if (!w_enq[i] && w_deq[i]) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge coh_clk_i or posedge coh_reset_i) begin
    if (coh_reset_i) begin
      r_state   <= c_idle;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_rem     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_rem   <= w_rem_nxt;
      if (w_pkt_done && (r_pkt_cnt != '1)) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  // Round-robin search from r_ptr; descending offset so the nearest wins.
  always_comb begin
    w_gnt_idx = r_ptr;
    w_gnt_v   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = num_in_p - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (c_ptr_w+1)'(k);
      if (w_sum >= c_num_in) w_sum = w_sum - c_num_in;
      w_cand = w_sum[c_ptr_w-1:0];
      if (w_req[w_cand]) begin
        w_gnt_v   = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    w_sel      = (r_state == c_locked) ? r_owner : w_gnt_idx;
    w_out_v    = ~coh_reset_i & ((r_state == c_locked) ? ~w_empty[r_owner] : w_gnt_v);
    w_out_data = w_head[w_sel];
    w_xfer     = w_out_v & out_link_i[0];
    w_len      = w_out_data[len_lsb_p +: len_width_p];
    w_deq      = '0;
    if (w_xfer) w_deq[w_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_rem_nxt   = r_rem;
    w_pkt_done  = 1'b0;
    case (r_state)
      c_idle: begin
        if (w_xfer) begin
          w_ptr_nxt = (w_gnt_idx == c_last_ch) ? '0 : w_gnt_idx + 1'b1;
          if (w_len != '0) begin
            w_state_nxt = c_locked;
            w_owner_nxt = w_gnt_idx;
            w_rem_nxt   = w_len;
          end else begin
            w_pkt_done = 1'b1;
          end
        end
      end
      c_locked: begin
        if (w_xfer) begin
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == c_rem_one) begin
            w_state_nxt = c_idle;
            w_pkt_done  = 1'b1;
          end
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  assign out_link_o  = {w_out_v, w_out_data, 1'b0};
  assign pkt_count_o = r_pkt_cnt;

  logic w_unused_bits;
  assign w_unused_bits = ^{out_link_i[flit_width_p+1:1], w_in_rr};

endmodule
`default_nettype wire

// File: tb/tb_bp_coh_wormhole_concentrator.sv
`default_nettype none
// Directed bench for bp_coh_wormhole_concentrator: single packet, fairness,
// backpressure, no-interleave, disable, reset mid-packet and saturation.
module tb_bp_coh_wormhole_concentrator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        in_v = '0;
  logic [63:0]       in_d [4];
  logic              out_rdy = 1'b0;
  logic [3:0]        chan_en = 4'b1111;
  logic [3:0][65:0]  in_link;
  logic [3:0][65:0]  in_link_ret, sat_in_link_ret;
  logic [65:0]       out_link, sat_out_link, out_link_back;
  logic [15:0]       pkt_cnt;
  logic [1:0]        sat_cnt;
  logic [3:0]        rdy;
  logic              out_v;
  logic [63:0]       out_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      in_link[i] = {in_v[i], in_d[i], 1'b0};
      rdy[i]     = in_link_ret[i][0];
    end
    out_link_back = {65'd0, out_rdy};
    out_v = out_link[65];
    out_d = out_link[64:1];
  end

  bp_coh_wormhole_concentrator dut (
    .coh_clk_i(clk), .coh_reset_i(rst),
    .in_link_i(in_link), .in_link_o(in_link_ret),
    .out_link_o(out_link), .out_link_i(out_link_back),
    .chan_en_i(chan_en), .pkt_count_o(pkt_cnt)
  );

  bp_coh_wormhole_concentrator #(.cnt_width_p(2)) dut_sat (
    .coh_clk_i(clk), .coh_reset_i(rst),
    .in_link_i(in_link), .in_link_o(sat_in_link_ret),
    .out_link_o(sat_out_link), .out_link_i(out_link_back),
    .chan_en_i(chan_en), .pkt_count_o(sat_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [63:0] q_data [$];
  int          q_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_v && out_rdy) begin
      q_data.push_back(out_d);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fl(input int ch, input int seq, input int len);
    return {8'(ch), 8'(seq), 44'd0, 4'(len)};
  endfunction

  task automatic send(input int ch, input logic [63:0] f);
    bit ok = 1'b0;
    in_v[ch] = 1'b1;
    in_d[ch] = f;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = rdy[ch];
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("send_ch%0d", ch), 64'(ok), 64'd1);
    in_v[ch] = 1'b0;
  endtask

  task automatic wait_q(input int n);
    for (int t = 0; t < 200 && q_data.size() < n; t++) @(posedge clk);
    #1;
    check_eq($sformatf("drain_%0d", n), 64'(q_data.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_v = '0;
    out_rdy = 1'b0;
    chan_en = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_data.delete();
    q_cyc.delete();
  endtask

  task automatic send_pair(input int ch);
    send(ch, fl(ch, 0, 0));
    send(ch, fl(ch, 1, 0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_d[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_v", 64'(out_v), 64'd0);
    check_eq("rst_rdy", 64'(rdy), 64'd0);
    check_eq("rst_cnt", 64'(pkt_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_rdy", 64'(rdy), 64'hf);

    // Single packet, L=2
    do_reset();
    out_rdy = 1'b1;
    send(0, fl(0, 0, 2));
    send(0, fl(0, 1, 0));
    send(0, fl(0, 2, 0));
    wait_q(3);
    for (int i = 0; i < 3; i++) check_eq($sformatf("single_d%0d", i), q_data[i], fl(0, i, i == 0 ? 2 : 0));
    check_eq("single_gap01", 64'(q_cyc[1] - q_cyc[0]), 64'd1);
    check_eq("single_gap12", 64'(q_cyc[2] - q_cyc[1]), 64'd1);
    check_eq("single_cnt", 64'(pkt_cnt), 64'd1);

    // Backpressure then round-robin fairness
    do_reset();
    fork
      send_pair(0);
      send_pair(1);
      send_pair(2);
      send_pair(3);
    join
    in_v[0] = 1'b1;
    in_d[0] = fl(0, 9, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_rdy", 64'(rdy), 64'd0);
    check_eq("bp_out_v", 64'(out_v), 64'd1);
    check_eq("bp_hold_d", out_d, fl(0, 0, 0));
    in_v[0] = 1'b0;
    out_rdy = 1'b1;
    wait_q(8);
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_no_extra", 64'(q_data.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_%0d", i), q_data[i], fl(i % 4, i / 4, 0));
    check_eq("rr_cnt", 64'(pkt_cnt), 64'd8);
    check_eq("rr_rdy", 64'(rdy), 64'hf);

    // No interleave across a bubble
    do_reset();
    out_rdy = 1'b1;
    fork
      begin
        send(1, fl(1, 0, 3));
        send(1, fl(1, 1, 0));
        @(posedge clk);
        #1;
        send(1, fl(1, 2, 0));
        send(1, fl(1, 3, 0));
      end
      begin
        @(posedge clk);
        #1;
        send(2, fl(2, 0, 0));
      end
    join
    wait_q(5);
    for (int i = 0; i < 4; i++) check_eq($sformatf("lock_d%0d", i), q_data[i], fl(1, i, i == 0 ? 3 : 0));
    check_eq("lock_ch2", q_data[4], fl(2, 0, 0));
    check_eq("lock_bubble", 64'(q_cyc[2] - q_cyc[1]), 64'd2);
    check_eq("lock_cnt", 64'(pkt_cnt), 64'd2);

    // Disable channel 0 mid-packet
    do_reset();
    out_rdy = 1'b1;
    send(0, fl(0, 0, 2));
    wait_q(1);
    chan_en = 4'b1110;
    send(0, fl(0, 1, 0));
    send(0, fl(0, 2, 0));
    wait_q(3);
    check_eq("dis_b2", q_data[2], fl(0, 2, 0));
    send(0, fl(0, 3, 0));
    repeat (5) @(posedge clk);
    #1;
    check_eq("dis_blocked", 64'(q_data.size()), 64'd3);
    check_eq("dis_out_v", 64'(out_v), 64'd0);
    send(3, fl(3, 0, 0));
    wait_q(4);
    check_eq("dis_ch3", q_data[3], fl(3, 0, 0));
    chan_en = 4'b1111;
    wait_q(5);
    check_eq("dis_reen", q_data[4], fl(0, 3, 0));
    check_eq("dis_cnt", 64'(pkt_cnt), 64'd3);

    // Reset in the middle of an L=5 packet
    do_reset();
    out_rdy = 1'b1;
    send(0, fl(0, 0, 5));
    send(0, fl(0, 1, 0));
    send(0, fl(0, 2, 0));
    check_eq("mid_sent2", 64'(q_data.size()), 64'd2);
    rst = 1'b1;
    #1;
    check_eq("mid_out_v", 64'(out_v), 64'd0);
    check_eq("mid_cnt", 64'(pkt_cnt), 64'd0);
    check_eq("mid_rdy", 64'(rdy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("mid_rdy_rel", 64'(rdy), 64'hf);
    q_data.delete();
    q_cyc.delete();
    send(1, fl(1, 7, 0));
    wait_q(1);
    check_eq("mid_fresh", q_data[0], fl(1, 7, 0));
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_no_resume", 64'(q_data.size()), 64'd1);
    check_eq("mid_cnt1", 64'(pkt_cnt), 64'd1);

    // Counter saturation
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) send(0, fl(0, i, 0));
    wait_q(5);
    check_eq("sat_main", 64'(pkt_cnt), 64'd5);
    check_eq("sat_2bit", 64'(sat_cnt), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
